cix32_mem_arbiter: RTL and testbench
====================================

CIX32_MEM_ARBITER -- requirements
Module: cix32_mem_arbiter

Interface
REQ-001 Parameter: MAX_D_STREAK, default 4, is the maximum number of consecutive data grants while an instruction request is pending.
REQ-002 Parameter: TIMEOUT_CYCLES, default 255, is the number of BUSY cycles without mem_ack before the transaction aborts.
REQ-003 Clock and reset SHALL be clk (rising edge) and rst_n (asynchronous, active-low).
REQ-004 Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- imem_req  in  1  fetch request, held until imem_ready
- imem_addr  in  32  fetch address
- imem_rdata  out  32  fetch data
- imem_ready  out  1  fetch complete pulse
- dmem_req  in  1  data request, held until dmem_ready
- dmem_we  in  1  1 = write
- dmem_addr  in  32  data address
- dmem_wdata  in  32  write data
- dmem_wstrb  in  4  byte strobes
- dmem_rdata  out  32  read data
- dmem_ready  out  1  data complete pulse
- mem_req  out  1  shared-bus request
- mem_we  out  1  shared-bus write
- mem_addr  out  32  shared-bus address
- mem_wdata  out  32  shared-bus write data
- mem_wstrb  out  4  shared-bus strobes
- mem_rdata  in  32  shared-bus read data
- mem_ack  in  1  shared-bus completion
- owner  out  2  0 = none, 1 = instruction, 2 = data
- bus_err  out  1  timeout pulse

Function
REQ-005 FSM states SHALL be IDLE, I_BUSY, D_BUSY and RESP; all outputs SHALL be registered.
REQ-006 In IDLE, the arbiter SHALL grant data over instruction, except that an instruction request SHALL win when the streak counter equals MAX_D_STREAK.
REQ-007 The streak counter SHALL increment on each data grant while imem_req=1, saturate at MAX_D_STREAK, and clear on any instruction grant or on any data grant with imem_req=0.
REQ-008 A grant in cycle N SHALL drive mem_req=1 and latch the request address, we, wdata and wstrb on the mem_* outputs from cycle N+1 until the cycle mem_ack is sampled.
REQ-009 Request inputs SHALL be ignored in BUSY and RESP.
REQ-010 mem_ack sampled high in cycle M SHALL:
- drop mem_req at M+1;
- enter RESP at M+1, pulsing the owner's ready for exactly one cycle with rdata valid;
- return to IDLE at M+2.
REQ-011 Minimum request-to-ready latency SHALL be 2 cycles.
REQ-012 For reads, the owner's rdata SHALL capture mem_rdata at ack; for writes, dmem_rdata SHALL be 32'h0. Rdata SHALL hold until the next completion for that port.
REQ-013 The timeout counter SHALL clear on entry to BUSY and increment each BUSY cycle without mem_ack.
REQ-014 On reaching TIMEOUT_CYCLES, the arbiter SHALL:
- enter RESP;
- pulse ready with rdata=32'hFFFFFFFF;
- pulse bus_err for 1 cycle;
- drop mem_req.
REQ-015 mem_ack arriving in the same cycle the count reaches TIMEOUT_CYCLES SHALL take precedence, with no bus_err.
REQ-016 mem_ack outside BUSY SHALL be ignored.
REQ-017 A requester dropping req mid-transaction SHALL NOT abort it; the ready pulse SHALL still be issued.
REQ-018 owner SHALL show the BUSY-state owner and remain unchanged through RESP.

Reset
REQ-019 While rst_n=0:
- state=IDLE;
- mem_req, mem_we, mem_wstrb, imem_ready, dmem_ready and bus_err = 0;
- mem_addr, mem_wdata, imem_rdata and dmem_rdata = 32'h0;
- owner=0; counters=0.
REQ-020 Reset asserted mid-transaction SHALL drop mem_req immediately, and no ready pulse SHALL follow.

Structure
REQ-021 The arb_state_t enum and the owner encoding constants (OWN_NONE, OWN_I, OWN_D) SHALL reside in cix32_pkg.
REQ-022 The timeout counter SHALL be one sub-module, cix32_arb_timeout (inputs clear and enable; output expired), parameterised by TIMEOUT_CYCLES.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Single fetch at 0x000FFFF0 with ack on the first mem_req cycle and mem_rdata=0x00000040 -> imem_ready two cycles after request, imem_rdata=0x40, owner=1.
- imem_req and dmem_req (write 0xDEADBEEF, wstrb=0xF, addr 0x100) in the same cycle -> data granted first with mem_we=1, dmem_rdata=0; instruction granted in the next IDLE.
- dmem_req held continuously with imem_req pending and MAX_D_STREAK=4 -> exactly 4 data grants, then 1 instruction grant.
- No mem_ack with TIMEOUT_CYCLES=8 -> bus_err and dmem_ready pulse together 8 cycles after grant, dmem_rdata=0xFFFFFFFF.
- mem_ack in the same cycle the timeout expires -> normal completion, bus_err=0.
- rst_n asserted during D_BUSY -> mem_req=0 immediately, no dmem_ready pulse, and a fresh fetch after release completes normally.

Source files
------------

// File: rtl/cix32_pkg.sv
// cix32_pkg: arbiter state encoding, bus-owner codes and shared constants
package cix32_pkg;
  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RESP} arb_state_t;
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I = 2'd1;
  localparam logic [1:0] OWN_D = 2'd2;
  localparam logic [31:0] ERR_RDATA = 32'hFFFF_FFFF;
  function automatic logic [1:0] state_owner(arb_state_t s);
    return s == I_BUSY ? OWN_I : s == D_BUSY ? OWN_D : OWN_NONE;
  endfunction
endpackage

// File: rtl/cix32_mem_arbiter_if.sv
// cix32_mem_arbiter_if: fetch port, data port and shared memory bus of the arbiter
interface cix32_mem_arbiter_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
           mem_rdata, mem_ack,
    output imem_rdata, imem_ready, dmem_rdata, dmem_ready,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
           mem_rdata, mem_ack,
    input  imem_rdata, imem_ready, dmem_rdata, dmem_ready,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/cix32_arb_timeout.sv
// cix32_arb_timeout: counts ack-less bus cycles and flags the one that reaches the limit
module cix32_arb_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
  logic [W-1:0] r_count;
  // restart on each new grant, advance on every waiting cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_count <= '0;
    else if (clear) r_count <= '0;
    else if (enable) r_count <= r_count + 1'b1;
  assign expired = enable & (r_count == LAST);
endmodule

// File: rtl/cix32_mem_arbiter.sv
// cix32_mem_arbiter: shares one memory bus between the fetch and data ports
module cix32_mem_arbiter
  import cix32_pkg::*;
#(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  cix32_mem_arbiter_if.slave bus,
  output logic [1:0]        owner,
  output logic              bus_err
);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  arb_state_t r_state, w_state;
  logic [1:0] r_owner, w_owner;
  logic [SW-1:0] r_streak, w_streak;
  logic r_mem_req, w_mem_req, r_mem_we, w_mem_we;
  logic [31:0] r_mem_addr, w_mem_addr, r_mem_wdata, w_mem_wdata;
  logic [3:0] r_mem_wstrb, w_mem_wstrb;
  logic [31:0] r_imem_rdata, w_imem_rdata, r_dmem_rdata, w_dmem_rdata;
  logic r_imem_ready, w_imem_ready, r_dmem_ready, w_dmem_ready, r_bus_err, w_bus_err;
  logic w_busy, w_grant_i, w_grant_d, w_ack, w_expired;
  logic [31:0] w_rdata;
  assign w_busy = (r_state == I_BUSY) | (r_state == D_BUSY);
  assign w_ack = w_busy & bus.mem_ack;
  // fetch only beats a data request once data has had its full streak
  assign w_grant_i = (r_state == IDLE) & bus.imem_req & (~bus.dmem_req | (r_streak == STREAK_MAX));
  assign w_grant_d = (r_state == IDLE) & bus.dmem_req & ~w_grant_i;
  assign w_rdata = ~w_ack ? ERR_RDATA : (r_state == D_BUSY && r_mem_we) ? 32'h0 : bus.mem_rdata;
  cix32_arb_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk),
    .rst_n(rst_n),
    .clear(w_grant_i | w_grant_d),
    .enable(w_busy & ~bus.mem_ack),
    .expired(w_expired)
  );
  // next state and next value of every registered output
  always_comb begin
    w_state = r_state;
    w_owner = r_owner;
    w_streak = r_streak;
    w_mem_req = r_mem_req;
    w_mem_we = r_mem_we;
    w_mem_addr = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_mem_wstrb = r_mem_wstrb;
    w_imem_rdata = r_imem_rdata;
    w_dmem_rdata = r_dmem_rdata;
    w_imem_ready = 1'b0;
    w_dmem_ready = 1'b0;
    w_bus_err = 1'b0;
    unique case (r_state)
      IDLE: if (w_grant_i | w_grant_d) begin
        w_state = w_grant_i ? I_BUSY : D_BUSY;
        w_owner = state_owner(w_state);
        w_streak = (w_grant_d & bus.imem_req) ? r_streak + (r_streak != STREAK_MAX) : '0;
        w_mem_req = 1'b1;
        w_mem_we = w_grant_d & bus.dmem_we;
        w_mem_addr = w_grant_i ? bus.imem_addr : bus.dmem_addr;
        w_mem_wdata = w_grant_i ? 32'h0 : bus.dmem_wdata;
        w_mem_wstrb = w_grant_i ? 4'h0 : bus.dmem_wstrb;
      end
      I_BUSY, D_BUSY: if (w_ack | w_expired) begin
        w_state = RESP;
        w_mem_req = 1'b0;
        w_bus_err = w_expired;
        w_imem_ready = r_state == I_BUSY;
        w_dmem_ready = r_state == D_BUSY;
        w_imem_rdata = r_state == I_BUSY ? w_rdata : r_imem_rdata;
        w_dmem_rdata = r_state == D_BUSY ? w_rdata : r_dmem_rdata;
      end
      default: begin
        w_state = IDLE;
        w_owner = OWN_NONE;
      end
    endcase
  end
  // state and output registers; reset kills any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_owner <= OWN_NONE;
      r_streak <= '0;
      r_mem_req <= 1'b0;
      r_mem_we <= 1'b0;
      r_mem_addr <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_mem_wstrb <= 4'h0;
      r_imem_rdata <= 32'h0;
      r_dmem_rdata <= 32'h0;
      r_imem_ready <= 1'b0;
      r_dmem_ready <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_state;
      r_owner <= w_owner;
      r_streak <= w_streak;
      r_mem_req <= w_mem_req;
      r_mem_we <= w_mem_we;
      r_mem_addr <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_mem_wstrb <= w_mem_wstrb;
      r_imem_rdata <= w_imem_rdata;
      r_dmem_rdata <= w_dmem_rdata;
      r_imem_ready <= w_imem_ready;
      r_dmem_ready <= w_dmem_ready;
      r_bus_err <= w_bus_err;
    end
  end
  assign bus.mem_req = r_mem_req;
  assign bus.mem_we = r_mem_we;
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_wstrb = r_mem_wstrb;
  assign bus.imem_rdata = r_imem_rdata;
  assign bus.imem_ready = r_imem_ready;
  assign bus.dmem_rdata = r_dmem_rdata;
  assign bus.dmem_ready = r_dmem_ready;
  assign owner = r_owner;
  assign bus_err = r_bus_err;
endmodule

// File: tb/tb_cix32_mem_arbiter.sv
// tb_cix32_mem_arbiter: directed scenarios plus random traffic against a transaction model
module tb_cix32_mem_arbiter;
  localparam int MAXS = 4;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] owner;
  logic bus_err;
  int errors = 0;
  int checks = 0;
  cix32_mem_arbiter_if bif();
  cix32_mem_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif), .owner(owner), .bus_err(bus_err)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // model: one transaction at a time; phase 0 waiting, 1 on the bus, 2 reporting
  int m_phase, m_age, m_streak;
  logic [1:0] m_own;
  logic m_req, m_we, m_irdy, m_drdy, m_err;
  logic [31:0] m_addr, m_wdata, m_ird, m_drd, m_d;
  logic [3:0] m_wstrb;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_age = 0; m_streak = 0; m_own = 2'd0;
      m_req = 0; m_we = 0; m_irdy = 0; m_drdy = 0; m_err = 0;
      m_addr = 0; m_wdata = 0; m_ird = 0; m_drd = 0; m_wstrb = 0;
    end else begin
      m_irdy = 0; m_drdy = 0; m_err = 0;
      if (m_phase == 2) begin
        m_phase = 0; m_own = 2'd0;
      end else if (m_phase == 1) begin
        m_age++;
        if (bif.mem_ack || m_age == TO) begin
          m_d = !bif.mem_ack ? 32'hFFFFFFFF : (m_own == 2'd2 && m_we) ? 32'h0 : bif.mem_rdata;
          m_err = !bif.mem_ack;
          m_phase = 2; m_req = 0;
          if (m_own == 2'd1) begin m_irdy = 1; m_ird = m_d; end
          else begin m_drdy = 1; m_drd = m_d; end
        end
      end else if (bif.imem_req && (!bif.dmem_req || m_streak >= MAXS)) begin
        m_phase = 1; m_age = 0; m_own = 2'd1; m_req = 1; m_we = 0;
        m_addr = bif.imem_addr; m_streak = 0;
      end else if (bif.dmem_req) begin
        m_phase = 1; m_age = 0; m_own = 2'd2; m_req = 1; m_we = bif.dmem_we;
        m_addr = bif.dmem_addr; m_wdata = bif.dmem_wdata; m_wstrb = bif.dmem_wstrb;
        m_streak = bif.imem_req ? (m_streak < MAXS ? m_streak + 1 : MAXS) : 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("mem_req", 32'(bif.mem_req), 32'(m_req));
    chk("owner", 32'(owner), 32'(m_own));
    chk("bus_err", 32'(bus_err), 32'(m_err));
    chk("imem_ready", 32'(bif.imem_ready), 32'(m_irdy));
    chk("dmem_ready", 32'(bif.dmem_ready), 32'(m_drdy));
    chk("imem_rdata", bif.imem_rdata, m_ird);
    chk("dmem_rdata", bif.dmem_rdata, m_drd);
    if (m_req) chk("mem_addr", bif.mem_addr, m_addr);
    if (m_req && m_own == 2'd2) begin
      chk("mem_we", 32'(bif.mem_we), 32'(m_we));
      chk("mem_wdata", bif.mem_wdata, m_wdata);
      chk("mem_wstrb", 32'(bif.mem_wstrb), 32'(m_wstrb));
    end
  end

  // requesters and memory responder
  bit rnd_on, i_hold, d_hold, rd_fixed_en;
  int ack_delay, resp_cnt, r;
  logic [31:0] rd_fixed;
  task automatic drive();
    if (bif.imem_ready && !i_hold) bif.imem_req = 0;
    if (bif.dmem_ready && !d_hold) bif.dmem_req = 0;
    if (rnd_on) begin
      if (!bif.imem_req && $urandom_range(3) == 0) begin
        bif.imem_req = 1; bif.imem_addr = $urandom;
      end else if (bif.imem_req && $urandom_range(31) == 0) bif.imem_req = 0;
      if (!bif.dmem_req && $urandom_range(2) == 0) begin
        bif.dmem_req = 1; bif.dmem_we = $urandom_range(1) == 1; bif.dmem_addr = $urandom;
        bif.dmem_wdata = $urandom; bif.dmem_wstrb = 4'($urandom);
      end else if (bif.dmem_req && $urandom_range(31) == 0) bif.dmem_req = 0;
    end
    if (bif.mem_req) begin
      bif.mem_ack = resp_cnt == ack_delay;
      resp_cnt++;
    end else begin
      resp_cnt = 0;
      bif.mem_ack = rnd_on && $urandom_range(1) == 1;
      if (rnd_on) begin
        r = $urandom_range(15);
        ack_delay = r < 12 ? r % 4 : r < 14 ? TO - 1 : TO;
      end
    end
    bif.mem_rdata = rd_fixed_en ? rd_fixed : $urandom;
  endtask
  task automatic cyc();
    @(negedge clk);
    #1;
    drive();
  endtask

  int nd;
  bit got_i, prev;
  initial begin
    rst_n = 0;
    bif.imem_req = 0; bif.imem_addr = 0; bif.dmem_req = 0; bif.dmem_we = 0;
    bif.dmem_addr = 0; bif.dmem_wdata = 0; bif.dmem_wstrb = 0; bif.mem_rdata = 0; bif.mem_ack = 0;
    rnd_on = 0; i_hold = 0; d_hold = 0; rd_fixed_en = 1; rd_fixed = 0; ack_delay = 0; resp_cnt = 0;
    repeat (3) cyc();
    chk("rst_mem_req", 32'(bif.mem_req), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_mem_addr", bif.mem_addr, 32'h0);
    chk("rst_dmem_rdata", bif.dmem_rdata, 32'h0);
    rst_n = 1;
    repeat (2) cyc();
    // single fetch, ack on first bus cycle
    rd_fixed = 32'h40; ack_delay = 0;
    bif.imem_addr = 32'h000FFFF0; bif.imem_req = 1;
    cyc();
    chk("s1_mem_req", 32'(bif.mem_req), 32'h1);
    chk("s1_owner", 32'(owner), 32'h1);
    chk("s1_mem_addr", bif.mem_addr, 32'h000FFFF0);
    chk("s1_early_ready", 32'(bif.imem_ready), 32'h0);
    cyc();
    chk("s1_ready", 32'(bif.imem_ready), 32'h1);
    chk("s1_rdata", bif.imem_rdata, 32'h40);
    chk("s1_model_rdata", m_ird, 32'h40);
    chk("s1_owner_resp", 32'(owner), 32'h1);
    repeat (3) cyc();
    // simultaneous fetch and data write: data first
    rd_fixed = 32'h77;
    bif.imem_addr = 32'h2000; bif.imem_req = 1;
    bif.dmem_addr = 32'h100; bif.dmem_we = 1; bif.dmem_wdata = 32'hDEADBEEF; bif.dmem_wstrb = 4'hF;
    bif.dmem_req = 1;
    cyc();
    chk("s2_owner_d", 32'(owner), 32'h2);
    chk("s2_we", 32'(bif.mem_we), 32'h1);
    chk("s2_addr", bif.mem_addr, 32'h100);
    chk("s2_wdata", bif.mem_wdata, 32'hDEADBEEF);
    chk("s2_wstrb", 32'(bif.mem_wstrb), 32'hF);
    cyc();
    chk("s2_dready", 32'(bif.dmem_ready), 32'h1);
    chk("s2_drdata", bif.dmem_rdata, 32'h0);
    cyc();
    chk("s2_idle_owner", 32'(owner), 32'h0);
    cyc();
    chk("s2_owner_i", 32'(owner), 32'h1);
    chk("s2_iaddr", bif.mem_addr, 32'h2000);
    cyc();
    chk("s2_iready", 32'(bif.imem_ready), 32'h1);
    chk("s2_irdata", bif.imem_rdata, 32'h77);
    repeat (3) cyc();
    // data held with fetch pending: streak limit
    bif.imem_addr = 32'h3000; bif.dmem_addr = 32'h400; bif.dmem_we = 0;
    d_hold = 1; bif.imem_req = 1; bif.dmem_req = 1;
    nd = 0; got_i = 0; prev = 0;
    for (int c = 0; c < 80 && !got_i; c++) begin
      cyc();
      if (bif.mem_req && !prev) begin
        if (owner == 2'd2) nd++;
        else if (owner == 2'd1) got_i = 1;
      end
      prev = bif.mem_req;
    end
    d_hold = 0; bif.dmem_req = 0;
    chk("s3_d_grants", 32'(nd), 32'd4);
    chk("s3_i_grant", 32'(got_i), 32'h1);
    repeat (5) cyc();
    // timeout with no ack
    ack_delay = 1000; bif.dmem_addr = 32'h200; bif.dmem_we = 0; bif.dmem_req = 1;
    repeat (8) cyc();
    chk("s4_err_early", 32'(bus_err), 32'h0);
    chk("s4_req_held", 32'(bif.mem_req), 32'h1);
    cyc();
    chk("s4_bus_err", 32'(bus_err), 32'h1);
    chk("s4_dready", 32'(bif.dmem_ready), 32'h1);
    chk("s4_drdata", bif.dmem_rdata, 32'hFFFFFFFF);
    chk("s4_model_err", 32'(m_err), 32'h1);
    chk("s4_mem_req", 32'(bif.mem_req), 32'h0);
    repeat (3) cyc();
    // ack on the very cycle the timeout would expire
    ack_delay = TO - 1; rd_fixed = 32'h12345678; bif.dmem_addr = 32'h300; bif.dmem_req = 1;
    repeat (9) cyc();
    chk("s5_dready", 32'(bif.dmem_ready), 32'h1);
    chk("s5_bus_err", 32'(bus_err), 32'h0);
    chk("s5_drdata", bif.dmem_rdata, 32'h12345678);
    repeat (3) cyc();
    // reset during a data transaction
    ack_delay = 1000; bif.dmem_addr = 32'h500; bif.dmem_req = 1;
    repeat (3) cyc();
    chk("s6_busy", 32'(bif.mem_req), 32'h1);
    rst_n = 0;
    #1;
    chk("s6_req_drop", 32'(bif.mem_req), 32'h0);
    bif.dmem_req = 0;
    repeat (2) begin
      cyc();
      chk("s6_no_dready", 32'(bif.dmem_ready), 32'h0);
    end
    rst_n = 1;
    cyc();
    ack_delay = 2; rd_fixed = 32'h55; bif.imem_addr = 32'h4000; bif.imem_req = 1;
    repeat (3) cyc();
    chk("s6_not_yet", 32'(bif.imem_ready), 32'h0);
    cyc();
    chk("s6_iready", 32'(bif.imem_ready), 32'h1);
    chk("s6_irdata", bif.imem_rdata, 32'h55);
    repeat (3) cyc();
    // random traffic
    rnd_on = 1; rd_fixed_en = 0;
    repeat (3000) cyc();
    rnd_on = 0; bif.imem_req = 0; bif.dmem_req = 0;
    repeat (20) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
